// File: rtl/div_16x8_seq.sv
// div_16x8_seq: sequential 16/8 unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN: a zero divisor finishes in one iteration and raises dz.
module div_16x8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        busy,
    output logic        done,
    output logic        dz
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] qreg_q, qreg_d, q_q, q_d;
    logic [8:0]  p_q, p_d, p_sh;
    logic [7:0]  b_q, b_d, r_q, r_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ge;
`ifdef DIV_ZERO_DETECT_EN
    logic        dz_q, dz_d;
`endif
    always_comb begin
        p_sh    = {p_q[7:0], qreg_q[15]};
        ge      = p_sh >= {1'b0, b_q};
        state_d = state_q;
        qreg_d  = qreg_q;
        p_d     = p_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? RUN : IDLE;
                if (start) begin
                    qreg_d = a;
                    b_d    = b;
                    p_d    = 9'd0;
                    cnt_d  = 4'd0;
                end
            end
            RUN: begin
`ifdef DIV_ZERO_DETECT_EN
                if (b_q == 8'd0) begin
                    state_d = DONE;
                    q_d     = 16'hFFFF;
                    r_d     = qreg_q[7:0];
                    dz_d    = 1'b1;
                end else
`endif
                begin
                    p_d    = ge ? p_sh - {1'b0, b_q} : p_sh;
                    qreg_d = {qreg_q[14:0], ge};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = DONE;
                        q_d     = qreg_d;
                        r_d     = p_d[7:0];
`ifdef DIV_ZERO_DETECT_EN
                        dz_d    = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            qreg_q  <= '0;
            p_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            qreg_q  <= qreg_d;
            p_q     <= p_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end
`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) dz_q <= 1'b0;
        else     dz_q <= dz_d;
    end
    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif
    assign q    = q_q;
    assign r    = r_q;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
endmodule

// File: tb/tb_div_16x8_seq.sv
// tb_div_16x8_seq: randomized and directed checks of div_16x8_seq against a / and % reference.
module tb_div_16x8_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [7:0]  b = '0;
    logic [15:0] q;
    logic [7:0]  r;
    logic        busy, done, dz;
    int checks = 0;
    int errors = 0;

    div_16x8_seq dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                      .q(q), .r(r), .busy(busy), .done(done), .dz(dz));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] x, input logic [7:0] y);
        return (y == 8'd0) ? 16'hFFFF : x / {8'd0, y};
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] x, input logic [7:0] y);
        logic [15:0] m;
        m = (y == 8'd0) ? x : x % {8'd0, y};
        return m[7:0];
    endfunction

    function automatic logic ref_dz(input logic [7:0] y);
`ifdef DIV_ZERO_DETECT_EN
        return y == 8'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_lat(input logic [7:0] y);
`ifdef DIV_ZERO_DETECT_EN
        return (y == 8'd0) ? 2 : 17;
`else
        return 17;
`endif
    endfunction

    task automatic run_div(input logic [15:0] x, input logic [7:0] y, input string tag);
        int n, nbusy;
        logic [15:0] eq;
        logic [7:0]  er;
        eq = ref_q(x, y);
        er = ref_r(x, y);
        a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        a = $urandom_range(0, 65535); b = $urandom_range(0, 255);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL %s accept: busy=%b done=%b need busy=1 done=0", tag, busy, done);
        end
        n = 0; nbusy = 1;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
            if (busy === 1'b1) nbusy++;
            if (busy === 1'b1 && done === 1'b1) begin
                checks++; errors++; $display("FAIL %s overlap: busy and done both high", tag);
            end
        end
        checks++;
        if (n + 1 !== ref_lat(y)) begin
            errors++; $display("FAIL %s latency: got %0d need %0d", tag, n + 1, ref_lat(y));
        end
        checks++;
        if (nbusy !== ref_lat(y) - 1) begin
            errors++; $display("FAIL %s busy_cycles: got %0d need %0d", tag, nbusy, ref_lat(y) - 1);
        end
        checks++;
        if (q !== eq || r !== er || dz !== ref_dz(y)) begin
            errors++;
            $display("FAIL %s result a=%0d b=%0d: q=%0d r=%0d dz=%b need q=%0d r=%0d dz=%b",
                     tag, x, y, q, r, dz, eq, er, ref_dz(y));
        end
        step();
        checks++;
        if (done !== 1'b0 || q !== eq || r !== er) begin
            errors++; $display("FAIL %s hold: done=%b q=%0d r=%0d need done=0 q=%0d r=%0d", tag, done, q, r, eq, er);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({q, r, busy, done, dz} !== 27'd0) begin
            errors++; $display("FAIL reset: q=%0d r=%0d busy=%b done=%b dz=%b need all 0", q, r, busy, done, dz);
        end
    endtask

    task automatic test_directed();
        run_div(16'd1000, 8'd7, "d1000_7");
        run_div(16'd65535, 8'd255, "d65535_255");
        run_div(16'd5, 8'd9, "d5_9");
        run_div(16'h1234, 8'd1, "d1234_1");
        run_div(16'hBEEF, 8'd0, "dbeef_0");
        run_div(16'd200, 8'd200, "d200_200");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [15:0] x;
            logic [7:0]  y;
            x = $urandom_range(0, 65535);
            y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_div(x, y, "rand");
        end
    endtask

    task automatic test_back_to_back();
        int n;
        a = 16'd100; b = 8'd10; start = 1'b1;
        step();
        a = 16'd99;
        n = 0;
        while (done !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (q !== 16'd10 || r !== 8'd0) begin
            errors++; $display("FAIL b2b first: q=%0d r=%0d need q=10 r=0", q, r);
        end
        step();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (n !== 17) begin
            errors++; $display("FAIL b2b spacing: got %0d need 17", n);
        end
        checks++;
        if (q !== 16'd9 || r !== 8'd9) begin
            errors++; $display("FAIL b2b second: q=%0d r=%0d need q=9 r=9", q, r);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int n;
        a = 16'd200; b = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        a = 16'd7; b = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (q !== 16'd66 || r !== 8'd2 || n !== 10) begin
            errors++; $display("FAIL ignore_start: q=%0d r=%0d steps=%0d need q=66 r=2 steps=10", q, r, n);
        end
        step();
    endtask

    task automatic test_mid_reset();
        int pulses;
        a = 16'd500; b = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({q, r, busy, done, dz} !== 27'd0) begin
            errors++; $display("FAIL mid_reset: q=%0d r=%0d busy=%b done=%b dz=%b need all 0", q, r, busy, done, dz);
        end
        pulses = 0;
        repeat (20) begin step(); if (done === 1'b1 || busy === 1'b1) pulses++; end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL mid_reset quiet: got %0d active cycles need 0", pulses);
        end
        run_div(16'd500, 8'd3, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
